endgame_message_ctrl: RTL and testbench

- Sequences the end-of-game text bitmaps ("you win" / "you lose"), both 80x20 pixels, with an 8-bit RGB colour and a transparent code.
- On a game-end event the block slides the message up the screen, blinks it for a fixed number of times, then holds it steady until the player presses restart.
- Drives each bitmap's draw enable and the top-left position fed to the rectangle/offset generator.
- Sits between the game-state logic and the bitmap drawers. All timing is referenced to the per-frame startOfFrame strobe.

---
 rtl/endgame_message_ctrl_pkg.sv | 23 ++
 rtl/endgame_message_ctrl_if.sv | 37 +++
 rtl/endgame_message_ctrl_frame_timer.sv | 43 ++++
 rtl/endgame_message_ctrl.sv | 152 +++++++++++++++
 tb/tb_endgame_message_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/endgame_message_ctrl_pkg.sv
// game_pkg: constants shared by the end-of-game message sequencer.
//   COORD_W            width of screen coordinates
//   SCREEN_W/SCREEN_H  visible screen size in pixels
//   MSG_W/MSG_H        size of the "you win" / "you lose" bitmaps
//   ST_*               sequencer state encodings
package game_pkg;

    localparam int COORD_W  = 11;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int MSG_W    = 80;
    localparam int MSG_H    = 20;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SLIDE = 2'd1;
    localparam state_t ST_BLINK = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/endgame_message_ctrl_if.sv
// Interface between the game-state logic / bitmap drawers and the
// end-of-game message sequencer.
//   startOfFrame  one-cycle pulse at each frame start
//   gameWon       one-cycle pulse, player won
//   gameLost      one-cycle pulse, player lost
//   restartKey    debounced restart key level
//   drawWin       draw enable of the "you win" bitmap
//   drawLose      draw enable of the "you lose" bitmap
//   topLeftX/Y    message top-left corner
//   msgActive     high whenever a message sequence is running
//   restartReq    one-cycle restart pulse to the game-state logic
// master = game side (drives events), slave = sequencer.
interface endgame_message_ctrl_if;
    import game_pkg::*;

    logic               startOfFrame;
    logic               gameWon;
    logic               gameLost;
    logic               restartKey;
    logic               drawWin;
    logic               drawLose;
    logic [COORD_W-1:0] topLeftX;
    logic [COORD_W-1:0] topLeftY;
    logic               msgActive;
    logic               restartReq;

    modport master (
        output startOfFrame, gameWon, gameLost, restartKey,
        input  drawWin, drawLose, topLeftX, topLeftY, msgActive, restartReq
    );

    modport slave (
        input  startOfFrame, gameWon, gameLost, restartKey,
        output drawWin, drawLose, topLeftX, topLeftY, msgActive, restartReq
    );

endinterface

// File: rtl/endgame_message_ctrl_frame_timer.sv
// frame_timer: counts tick_i pulses modulo TERM and strobes tc_o on the
// pulse that wraps the count back to zero.
//   clk, resetN  clock and asynchronous active-low reset
//   clr_i        synchronous clear, overrides tick_i
//   tick_i       count enable (one frame pulse)
//   tc_o         terminal-count strobe, combinational from tick_i
module frame_timer #(
    parameter int TERM = 15
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr_i,
    input  logic tick_i,
    output logic tc_o
);

    localparam int CNT_W = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == CNT_W'(TERM - 1));
    assign tc_o    = tick_i & at_term & ~clr_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = at_term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/endgame_message_ctrl.sv
// endgame_message_ctrl: on a game-end pulse, slides the win/lose message up
// from START_Y to TARGET_Y (SLIDE_STEP pixels per frame), blinks it
// BLINK_TOGGLES times with BLINK_FRAMES frames per half-period, then holds it
// until a fresh rising edge of the restart key, which emits restartReq.
//   clk     system clock
//   resetN  asynchronous active-low reset
//   bus     endgame_message_ctrl_if slave port (events in, draw controls out)
// All outputs are registered.
module endgame_message_ctrl
    import game_pkg::*;
#(
    parameter int START_Y       = SCREEN_H,
    parameter int TARGET_Y      = (SCREEN_H - MSG_H) / 2,
    parameter int MSG_X         = (SCREEN_W - MSG_W) / 2,
    parameter int SLIDE_STEP    = 4,
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6      // must be even so the message ends visible
) (
    input  logic                  clk,
    input  logic                  resetN,
    endgame_message_ctrl_if.slave bus
);

    localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);

    state_t             state_q, state_d;
    logic               visible_q, visible_d;
    logic               win_latch_q, win_latch_d;
    logic [COORD_W-1:0] top_y_q, top_y_d;
    logic [COORD_W-1:0] top_x_q;
    logic [TOG_W-1:0]   toggle_cnt_q, toggle_cnt_d;
    logic               restart_req_q, restart_req_d;
    logic               draw_win_q, draw_lose_q;
    logic               msg_active_q;
    logic               key_q;

    logic               key_rise;
    logic               blink_tc;
    logic [COORD_W:0]   slide_next;   // one extra bit catches underflow
    logic               slide_done;

    assign key_rise   = bus.restartKey & ~key_q;
    assign slide_next = {1'b0, top_y_q} - (COORD_W+1)'(SLIDE_STEP);
    assign slide_done = slide_next[COORD_W] | (slide_next <= (COORD_W+1)'(TARGET_Y));

    // Held in clear outside BLINK, so the frame that enters BLINK is not counted.
    frame_timer #(
        .TERM (BLINK_FRAMES)
    ) u_blink_timer (
        .clk    (clk),
        .resetN (resetN),
        .clr_i  (state_q != ST_BLINK),
        .tick_i (bus.startOfFrame),
        .tc_o   (blink_tc)
    );

    always_comb begin
        state_d       = state_q;
        visible_d     = visible_q;
        win_latch_d   = win_latch_q;
        top_y_d       = top_y_q;
        toggle_cnt_d  = toggle_cnt_q;
        restart_req_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                visible_d = 1'b0;
                top_y_d   = COORD_W'(START_Y);
                if (bus.gameWon | bus.gameLost) begin
                    // Win wins a tie with a simultaneous loss.
                    win_latch_d = bus.gameWon;
                    visible_d   = 1'b1;
                    state_d     = ST_SLIDE;
                end
            end

            ST_SLIDE: begin
                if (bus.startOfFrame) begin
                    if (slide_done) begin
                        top_y_d      = COORD_W'(TARGET_Y);
                        toggle_cnt_d = '0;
                        state_d      = ST_BLINK;
                    end else begin
                        top_y_d = slide_next[COORD_W-1:0];
                    end
                end
            end

            ST_BLINK: begin
                if (blink_tc) begin
                    visible_d    = ~visible_q;
                    toggle_cnt_d = toggle_cnt_q + 1'b1;
                    if (toggle_cnt_q == TOG_W'(BLINK_TOGGLES - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                visible_d = 1'b1;
                if (key_rise) begin
                    restart_req_d = 1'b1;
                    visible_d     = 1'b0;
                    top_y_d       = COORD_W'(START_Y);
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            visible_q     <= 1'b0;
            win_latch_q   <= 1'b0;
            top_y_q       <= COORD_W'(START_Y);
            top_x_q       <= COORD_W'(MSG_X);
            toggle_cnt_q  <= '0;
            restart_req_q <= 1'b0;
            draw_win_q    <= 1'b0;
            draw_lose_q   <= 1'b0;
            msg_active_q  <= 1'b0;
            key_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            visible_q     <= visible_d;
            win_latch_q   <= win_latch_d;
            top_y_q       <= top_y_d;
            top_x_q       <= COORD_W'(MSG_X);
            toggle_cnt_q  <= toggle_cnt_d;
            restart_req_q <= restart_req_d;
            // Enables registered from next-state so they track visible with no extra lag.
            draw_win_q    <= visible_d & win_latch_d;
            draw_lose_q   <= visible_d & ~win_latch_d;
            msg_active_q  <= (state_d != ST_IDLE);
            // Tracked in every state so a key already held entering HOLD is not an edge.
            key_q         <= bus.restartKey;
        end
    end

    assign bus.drawWin    = draw_win_q;
    assign bus.drawLose   = draw_lose_q;
    assign bus.topLeftX   = top_x_q;
    assign bus.topLeftY   = top_y_q;
    assign bus.msgActive  = msg_active_q;
    assign bus.restartReq = restart_req_q;

endmodule

// File: tb/tb_endgame_message_ctrl.sv
// Scoreboard bench for endgame_message_ctrl. Each stimulus cycle updates a
// frame-count based reference model and queues the expected outputs; a
// monitor pops and compares one entry per clock.
module tb_endgame_message_ctrl;

    localparam int START_Y  = 480;
    localparam int TARGET_Y = 230;
    localparam int MSG_X    = 280;
    localparam int STEP     = 4;
    localparam int BF       = 15;
    localparam int BT       = 6;
    // Number of frames after the event at which the message reaches TARGET_Y.
    localparam int F0       = (START_Y - TARGET_Y + STEP - 1) / STEP;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    endgame_message_ctrl_if bus();

    endgame_message_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dw;
        logic        dl;
        logic [10:0] x;
        logic [10:0] y;
        logic        act;
        logic        req;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: active flag, winner, frames counted since the event,
    // previous key level, restart pulse.
    bit m_active, m_win, m_kprev, m_req;
    int m_f;

    logic key_lvl      = 1'b0;
    logic rst_lvl      = 1'b0;
    int   key_flip_pct = 0;

    task automatic model_reset();
        m_active = 0; m_win = 0; m_f = 0; m_kprev = 0; m_req = 0;
    endtask

    function automatic bit model_hold();
        return m_active && (m_f >= F0) && ((m_f - F0) >= BF * BT);
    endfunction

    task automatic model_clock(input bit sof, input bit won, input bit lost,
                               input bit key, input bit rstn);
        if (!rstn) begin
            model_reset();
            return;
        end
        m_req = 0;
        if (!m_active) begin
            if (won || lost) begin
                m_active = 1; m_win = won; m_f = 0;
            end
        end else if (model_hold()) begin
            if (key && !m_kprev) begin
                m_active = 0; m_req = 1;
            end
        end else if (sof) begin
            m_f++;
        end
        m_kprev = key;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        bit   vis;
        int   g;
        vis = 1;
        o.y = 11'(START_Y);
        if (m_active) begin
            if (m_f < F0) begin
                o.y = 11'(START_Y - STEP * m_f);
            end else begin
                o.y = 11'(TARGET_Y);
                g   = m_f - F0;
                if (g < BF * BT) vis = ((g / BF) % 2) == 0;
            end
        end
        o.dw  = m_active && vis && m_win;
        o.dl  = m_active && vis && !m_win;
        o.x   = 11'(MSG_X);
        o.act = m_active;
        o.req = m_req;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.dw  = bus.drawWin;
        o.dl  = bus.drawLose;
        o.x   = bus.topLeftX;
        o.y   = bus.topLeftY;
        o.act = bus.msgActive;
        o.req = bus.restartReq;
        return o;
    endfunction

    task automatic check(input string name, input obs_t a, input obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s @%0t: got dw=%0b dl=%0b x=%0d y=%0d act=%0b req=%0b, expected dw=%0b dl=%0b x=%0d y=%0d act=%0b req=%0b",
                         name, $time, a.dw, a.dl, a.x, a.y, a.act, a.req,
                         e.dw, e.dl, e.x, e.y, e.act, e.req);
        end
    endtask

    // Monitor: compares one queued expectation per clock, away from the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", sample(), e);
            end
        end
    end

    task automatic step(input bit sof, input bit won, input bit lost);
        @(negedge clk);
        if (key_flip_pct > 0 && $urandom_range(0, 99) < key_flip_pct) key_lvl = ~key_lvl;
        resetN           = rst_lvl;
        bus.startOfFrame = sof;
        bus.gameWon      = won;
        bus.gameLost     = lost;
        bus.restartKey   = key_lvl;
        model_clock(sof, won, lost, key_lvl, rst_lvl);
        exp_q.push_back(model_out());
    endtask

    function automatic bit rnd(input int pct);
        return (pct > 0) && ($urandom_range(0, 99) < pct);
    endfunction

    // n frames, each preceded by a random 1..3 cycle gap; ev_pct sprinkles events.
    task automatic frames(input int n, input int ev_pct);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(1, 3);
            for (int j = 0; j < gap; j++) step(1'b0, rnd(ev_pct), rnd(ev_pct));
            step(1'b1, rnd(ev_pct), rnd(ev_pct));
        end
    endtask

    task automatic press_restart();
        key_flip_pct = 0;
        key_lvl = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        key_lvl = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        key_lvl = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        $display("txn: restart key pressed, model req seen, t=%0t", $time);
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.gameWon      = 1'b0;
        bus.gameLost     = 1'b0;
        bus.restartKey   = 1'b0;
        model_reset();

        // Reset held, then idle for 10 frames.
        rst_lvl = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        #1 check("reset_values", sample(), model_out());
        rst_lvl = 1'b1;
        frames(10, 0);
        $display("txn: idle 10 frames, t=%0t", $time);

        // Win: slide, blink, hold; key chatter is ignored before HOLD.
        step(1'b0, 1'b1, 1'b0);
        $display("txn: gameWon, t=%0t", $time);
        key_flip_pct = 10;
        frames(170, 0);
        press_restart();

        // Win and loss together, then a stray loss during blinking.
        step(1'b0, 1'b1, 1'b1);
        $display("txn: gameWon+gameLost together, t=%0t", $time);
        frames(70, 0);
        step(1'b0, 1'b0, 1'b1);
        $display("txn: stray gameLost during blink, t=%0t", $time);
        frames(100, 0);
        press_restart();

        // Loss coinciding with a frame pulse; key held high across HOLD entry.
        key_lvl = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        $display("txn: gameLost with startOfFrame, key held, t=%0t", $time);
        frames(160, 0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        press_restart();

        // Random games with sporadic events and key activity.
        for (int k = 0; k < 3; k++) begin
            key_flip_pct = 5;
            step(1'b0, rnd(50), 1'b1);
            $display("txn: random game %0d, t=%0t", k, $time);
            frames(200, 3);
            press_restart();
        end

        // Asynchronous reset in the middle of the slide at topLeftY = 300.
        rst_lvl = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst_lvl = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        frames((START_Y - 300) / STEP, 0);
        @(negedge clk);
        #1;
        check("pre_reset_y300", sample(), model_out());
        resetN  = 1'b0;
        rst_lvl = 1'b0;
        model_reset();
        #1;
        check("async_reset", sample(), model_out());
        $display("txn: async reset mid-slide, t=%0t", $time);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        rst_lvl = 1'b1;
        frames(5, 0);

        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
